// File: rtl/sha_job_scheduler.sv
// sha_job_scheduler
//   Shares one SHA-2 engine between NUM_REQ AXI-Stream message sources. One message is in
//   flight at a time. The engine is granted round-robin per message. The granted source's
//   beats are forwarded to the engine, and the returned digest is sent out tagged with the
//   index of the source that owns it.
// Ports
//   axi_aclk, axi_resetn        clock, async active-low reset
//   req_*                       NUM_REQ packed requester streams (requester i at slice i)
//   req_sha_type                2 bits per requester; msb=1 selects SHA384/512
//   eng_en, eng_sha_type        engine control, held for the whole job
//   eng_s_axis_*                message stream to the engine
//   eng_m_axis_*                digest stream from the engine
//   m_axis_*                    digest stream out; m_axis_tid = owning requester
//   busy, jobs_done             status: not idle / completed-job count (wraps)
module sha_job_scheduler #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned DATA_WIDTH   = 512,
   parameter int unsigned DIGEST_WIDTH = 512,
   localparam int unsigned IDX_W       = $clog2(NUM_REQ)
) (
   input  logic                           axi_aclk,
   input  logic                           axi_resetn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_tdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_tkeep,
   input  logic [NUM_REQ-1:0]             req_tvalid,
   input  logic [NUM_REQ-1:0]             req_tlast,
   output logic [NUM_REQ-1:0]             req_tready,
   input  logic [2*NUM_REQ-1:0]           req_sha_type,
   output logic                           eng_en,
   output logic [1:0]                     eng_sha_type,
   output logic [DATA_WIDTH-1:0]          eng_s_axis_tdata,
   output logic [DATA_WIDTH/8-1:0]        eng_s_axis_tkeep,
   output logic                           eng_s_axis_tvalid,
   output logic                           eng_s_axis_tlast,
   input  logic                           eng_s_axis_tready,
   input  logic [DIGEST_WIDTH-1:0]        eng_m_axis_tdata,
   input  logic [DIGEST_WIDTH/8-1:0]      eng_m_axis_tkeep,
   input  logic                           eng_m_axis_tvalid,
   input  logic                           eng_m_axis_tlast,
   output logic                           eng_m_axis_tready,
   output logic [DIGEST_WIDTH-1:0]        m_axis_tdata,
   output logic [DIGEST_WIDTH/8-1:0]      m_axis_tkeep,
   output logic [IDX_W-1:0]               m_axis_tid,
   output logic                           m_axis_tvalid,
   output logic                           m_axis_tlast,
   input  logic                           m_axis_tready,
   output logic                           busy,
   output logic [31:0]                    jobs_done
);

   localparam int unsigned KEEP_W = DATA_WIDTH / 8;

   typedef enum logic [1:0] {StIdle, StSetup, StStream, StDigest} state_e;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [1:0]       sha_q, sha_d;
   logic [31:0]      jobs_q, jobs_d;

   logic [IDX_W-1:0] pick, cand;
   logic             any_valid;
   logic             sel_tvalid, sel_tlast;

   // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      pick      = rr_ptr_q;
      cand      = rr_ptr_q;
      any_valid = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
         if (!any_valid && req_tvalid[cand]) begin
            pick      = cand;
            any_valid = 1'b1;
         end
      end
   end

   assign sel_tvalid = req_tvalid[grant_q];
   assign sel_tlast  = req_tlast[grant_q];

   always_comb begin
      state_d           = state_q;
      rr_ptr_d          = rr_ptr_q;
      grant_d           = grant_q;
      sha_d             = sha_q;
      jobs_d            = jobs_q;
      req_tready        = '0;
      eng_en            = 1'b0;
      eng_s_axis_tdata  = '0;
      eng_s_axis_tkeep  = '0;
      eng_s_axis_tvalid = 1'b0;
      eng_s_axis_tlast  = 1'b0;
      eng_m_axis_tready = 1'b0;
      m_axis_tdata      = '0;
      m_axis_tkeep      = '0;
      m_axis_tid        = '0;
      m_axis_tvalid     = 1'b0;
      m_axis_tlast      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               grant_d = pick;
               sha_d   = req_sha_type[32'(pick) * 2 +: 2];
               state_d = StSetup;
            end
         end
         // One quiet cycle with eng_en high so the engine can latch sha_type.
         StSetup: begin
            eng_en  = 1'b1;
            state_d = StStream;
         end
         StStream: begin
            eng_en              = 1'b1;
            eng_s_axis_tdata    = req_tdata[32'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            eng_s_axis_tkeep    = req_tkeep[32'(grant_q) * KEEP_W +: KEEP_W];
            eng_s_axis_tvalid   = sel_tvalid;
            eng_s_axis_tlast    = sel_tlast;
            req_tready[grant_q] = eng_s_axis_tready;
            if (sel_tvalid && sel_tlast && eng_s_axis_tready) begin
               state_d = StDigest;
            end
         end
         StDigest: begin
            eng_en            = 1'b1;
            m_axis_tdata      = eng_m_axis_tdata;
            m_axis_tkeep      = eng_m_axis_tkeep;
            m_axis_tvalid     = eng_m_axis_tvalid;
            m_axis_tlast      = eng_m_axis_tlast;
            m_axis_tid        = grant_q;
            eng_m_axis_tready = m_axis_tready;
            if (eng_m_axis_tvalid && eng_m_axis_tlast && m_axis_tready) begin
               state_d  = StIdle;
               rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
               jobs_d   = jobs_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         sha_q    <= 2'b00;
         jobs_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         sha_q    <= sha_d;
         jobs_q   <= jobs_d;
      end
   end

   assign eng_sha_type = sha_q;
   assign busy         = (state_q != StIdle);
   assign jobs_done    = jobs_q;

endmodule
